rst_sequencer: RTL

- Generates the staged power-on and soft-reboot reset sequence for the pinmux domain.
- Drives `p_reset_n`, `clk_enb` and `s_reset_n` into the strap controller and the rest of the core, in the release order power-on reset → clock enable → soft reset.
- Also services the soft-reboot request from the strap sticky register (bit 31): it re-runs the clock-enable / soft-reset portion of the sequence while power-on state (sticky straps) is preserved.

---
 rtl/rst_seq_pkg.sv | 25 ++
 rtl/double_sync.sv | 24 ++
 rtl/rst_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and default delays for the pinmux-domain reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StPor,
    StClkWait,
    StSrstWait,
    StRun,
    StRbHold
  } rst_seq_st_t;

  localparam int unsigned RST_SEQ_P_DLY = 16;
  localparam int unsigned RST_SEQ_C_DLY = 8;
  localparam int unsigned RST_SEQ_S_DLY = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/double_sync.sv
// Two-flop level synchroniser with synchronous active-low reset.
module double_sync (
  input  logic clk,
  input  logic e_reset_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!e_reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/rst_sequencer.sv
// Staged power-on / soft-reboot reset sequencer: releases p_reset_n, then clk_enb, then
// s_reset_n; a soft-reboot request re-runs the clock-enable / soft-reset part only.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned P_DLY = RST_SEQ_P_DLY,
  parameter int unsigned C_DLY = RST_SEQ_C_DLY,
  parameter int unsigned S_DLY = RST_SEQ_S_DLY
) (
  input  logic       clk,
  input  logic       e_reset_n,
  input  logic       soft_reboot_req,
  output logic       p_reset_n,
  output logic       clk_enb,
  output logic       s_reset_n,
  output logic       seq_busy,
  output logic [7:0] reboot_cnt
);

  localparam int unsigned MaxDly = max3(P_DLY, C_DLY, S_DLY);
  localparam int unsigned CntW   = $clog2(MaxDly) + 1;

  localparam logic [CntW-1:0] PLoad = CntW'(P_DLY - 1);
  localparam logic [CntW-1:0] CLoad = CntW'(C_DLY - 1);
  localparam logic [CntW-1:0] SLoad = CntW'(S_DLY - 1);

  rst_seq_st_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            started_q;
  logic            req_s2;
  logic            req_s3_q;
  logic            req_rise;
  logic            cnt_done;
  logic [7:0]      reboot_cnt_q, reboot_cnt_d;
  logic            p_q, p_d;
  logic            ce_q, ce_d;
  logic            s_q, s_d;
  logic            busy_q, busy_d;

  double_sync u_req_sync (
    .clk       (clk),
    .e_reset_n (e_reset_n),
    .d_i       (soft_reboot_req),
    .q_o       (req_s2)
  );

  assign req_rise = req_s2 & ~req_s3_q;
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reboot_cnt_d = reboot_cnt_q;

    // The first edge after reset release only arms the counter, so POR spans P_DLY edges.
    if (started_q && !cnt_done) begin
      cnt_d = cnt_q - CntW'(1);
    end

    unique case (state_q)
      StPor: begin
        if (started_q && cnt_done) begin
          state_d = StClkWait;
          cnt_d   = CLoad;
        end
      end
      StClkWait: begin
        if (cnt_done) begin
          state_d = StSrstWait;
          cnt_d   = SLoad;
        end
      end
      StSrstWait: begin
        // Hold soft reset until the sticky logic has dropped the request.
        if (cnt_done && !req_s2) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (req_rise) begin
          state_d = StRbHold;
          cnt_d   = SLoad;
          if (reboot_cnt_q != 8'hFF) begin
            reboot_cnt_d = reboot_cnt_q + 8'd1;
          end
        end
      end
      StRbHold: begin
        if (cnt_done) begin
          state_d = StClkWait;
          cnt_d   = CLoad;
        end
      end
      default: begin
        state_d = StPor;
        cnt_d   = PLoad;
      end
    endcase
  end

  // Output flops follow the next state so outputs change on the same edge as the state.
  always_comb begin
    p_d    = (state_d != StPor);
    ce_d   = (state_d == StSrstWait) || (state_d == StRun) || (state_d == StRbHold);
    s_d    = (state_d == StRun);
    busy_d = (state_d != StRun);
  end

  always_ff @(posedge clk) begin
    if (!e_reset_n) begin
      state_q      <= StPor;
      cnt_q        <= PLoad;
      started_q    <= 1'b0;
      req_s3_q     <= 1'b0;
      reboot_cnt_q <= 8'd0;
      p_q          <= 1'b0;
      ce_q         <= 1'b0;
      s_q          <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      started_q    <= 1'b1;
      req_s3_q     <= req_s2;
      reboot_cnt_q <= reboot_cnt_d;
      p_q          <= p_d;
      ce_q         <= ce_d;
      s_q          <= s_d;
      busy_q       <= busy_d;
    end
  end

  assign p_reset_n  = p_q;
  assign clk_enb    = ce_q;
  assign s_reset_n  = s_q;
  assign seq_busy   = busy_q;
  assign reboot_cnt = reboot_cnt_q;

endmodule
